// File: rtl/tetris_sequencer_if.sv
// Handshake bundle between the tetris sequencer and its worker blocks.
//   master : sequencer side (drives *_start and candidate/anchor buses)
//   slave  : worker side (drives *_done, chk_hit, clr_rows)
// Signals:
//   chk_*  collision check of a candidate anchor/rotation
//   drw_*  draw (drw_clear = 0) or erase (drw_clear = 1) of the current piece
//   lock_* write the current piece into board RAM
//   clr_*  row clear, clr_rows = number of rows removed
//   rdw_*  full-board redraw
interface tetris_sequencer_if #(
   parameter int unsigned XW = 4,
   parameter int unsigned YW = 5
);
   logic          chk_start;
   logic [XW-1:0] chk_x;
   logic [YW-1:0] chk_y;
   logic [1:0]    chk_rot;
   logic          chk_done;
   logic          chk_hit;

   logic          drw_start;
   logic          drw_clear;
   logic [XW-1:0] drw_x;
   logic [YW-1:0] drw_y;
   logic [1:0]    drw_rot;
   logic          drw_done;

   logic          lock_start;
   logic          lock_done;

   logic          clr_start;
   logic          clr_done;
   logic [2:0]    clr_rows;

   logic          rdw_start;
   logic          rdw_done;

   modport master (
      output chk_start, chk_x, chk_y, chk_rot,
      input  chk_done, chk_hit,
      output drw_start, drw_clear, drw_x, drw_y, drw_rot,
      input  drw_done,
      output lock_start,
      input  lock_done,
      output clr_start,
      input  clr_done, clr_rows,
      output rdw_start,
      input  rdw_done
   );

   modport slave (
      input  chk_start, chk_x, chk_y, chk_rot,
      output chk_done, chk_hit,
      input  drw_start, drw_clear, drw_x, drw_y, drw_rot,
      output drw_done,
      input  lock_start,
      output lock_done,
      input  clr_start,
      output clr_done, clr_rows,
      input  rdw_start,
      output rdw_done
   );
endinterface

// File: rtl/tetris_sequencer.sv
// Master FSM for the tetris game: owns the falling piece (anchor, piece, rotation, gravity
// timer), arbitrates player input against gravity and sequences the worker blocks over
// start/done handshakes.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   bus (master)         worker handshakes (check, draw/erase, lock, row clear, redraw)
//   go_i                 start/restart game (level, edge-detected)
//   left_i/right_i/rotate_i  player moves (level, edge-detected)
//   drop_i               soft drop (level)
//   piece_o              current piece 0..6
//   game_over_o          high in the game-over state
//   score_o              accumulated score (saturating)
//   state_o              current FSM state, debug
//   level_o              speed level, only when TETRIS_SEQ_LEVEL_EN is defined
// Optional feature macro: TETRIS_SEQ_LEVEL_EN (level register shortening the gravity period).
// SOFT_DIV must be at least 1.
module tetris_sequencer #(
   parameter int unsigned BOARD_W        = 10,
   parameter int unsigned BOARD_H        = 24,
   parameter int unsigned SPAWN_X        = 4,
   parameter int unsigned GRAVITY_CYCLES = 25000000,
   parameter int unsigned SOFT_DIV       = 8,
   parameter int unsigned SCORE_W        = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   tetris_sequencer_if.master bus,
   input  logic               go_i,
   input  logic               left_i,
   input  logic               right_i,
   input  logic               rotate_i,
   input  logic               drop_i,
   output logic [2:0]         piece_o,
   output logic               game_over_o,
   output logic [SCORE_W-1:0] score_o,
`ifdef TETRIS_SEQ_LEVEL_EN
   output logic [3:0]         level_o,
`endif
   output logic [3:0]         state_o
);

   localparam int unsigned XW = $clog2(BOARD_W);
   localparam int unsigned YW = $clog2(BOARD_H);
   localparam int unsigned CW = $clog2(GRAVITY_CYCLES + 1);

   typedef enum logic [3:0] {
      StIdle   = 4'd0,
      StSpawn  = 4'd1,
      StSchk   = 4'd2,
      StWaitIn = 4'd3,
      StMchk   = 4'd4,
      StErase  = 4'd5,
      StDraw   = 4'd6,
      StLock   = 4'd7,
      StClr    = 4'd8,
      StRedraw = 4'd9,
      StOver   = 4'd10
   } state_e;

   state_e state_q, state_d;
   logic [2:0] rng_q, rng_d;
   logic [2:0] piece_q, piece_d;
   logic [XW-1:0] cur_x_q, cur_x_d, cand_x_q, cand_x_d;
   logic [YW-1:0] cur_y_q, cur_y_d, cand_y_q, cand_y_d;
   logic [1:0] cur_rot_q, cur_rot_d, cand_rot_q, cand_rot_d;
   logic mv_grav_q, mv_grav_d;
   logic [CW-1:0] gcnt_q, gcnt_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic chk_start_q, chk_start_d, drw_start_q, drw_start_d, drw_clear_q, drw_clear_d;
   logic lock_start_q, lock_start_d, clr_start_q, clr_start_d, rdw_start_q, rdw_start_d;
   logic go_prev_q, left_prev_q, right_prev_q, rotate_prev_q;

`ifdef TETRIS_SEQ_LEVEL_EN
   logic [3:0] level_q, level_d;
   logic [3:0] rows_q, rows_d;    // cleared rows since the last level step, 0..9
   logic [3:0] rows_sum;
`endif

   logic go_rise, left_rise, right_rise, rotate_rise;
   assign go_rise     = go_i & ~go_prev_q;
   assign left_rise   = left_i & ~left_prev_q;
   assign right_rise  = right_i & ~right_prev_q;
   assign rotate_rise = rotate_i & ~rotate_prev_q;

   // Gravity period: level shift first, then soft-drop divide, each clamped to 1.
   logic [31:0] base_per, per;
   logic        grav_fire;
   always_comb begin
`ifdef TETRIS_SEQ_LEVEL_EN
      base_per = GRAVITY_CYCLES >> level_q;
`else
      base_per = GRAVITY_CYCLES;
`endif
      if (base_per == 32'd0) base_per = 32'd1;
      per = drop_i ? (base_per / SOFT_DIV) : base_per;
      if (per == 32'd0) per = 32'd1;
   end
   assign grav_fire = (32'(gcnt_q) >= (per - 32'd1));

   // Line-clear scoring with saturation; more than 4 rows counts as 4.
   logic [2:0]       rows_sat;
   logic [3:0]       pts;
   logic [SCORE_W:0] score_sum;
   logic [SCORE_W-1:0] score_sat;
   always_comb begin
      rows_sat = (bus.clr_rows > 3'd4) ? 3'd4 : bus.clr_rows;
      case (rows_sat)
         3'd0:    pts = 4'd0;
         3'd1:    pts = 4'd1;
         3'd2:    pts = 4'd3;
         3'd3:    pts = 4'd5;
         default: pts = 4'd8;
      endcase
      score_sum = {1'b0, score_q} + (SCORE_W + 1)'(pts);
      score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
   end

   assign rng_d = (rng_q == 3'd6) ? 3'd0 : rng_q + 3'd1;

   always_comb begin
      state_d      = state_q;
      piece_d      = piece_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      cur_rot_d    = cur_rot_q;
      cand_x_d     = cand_x_q;
      cand_y_d     = cand_y_q;
      cand_rot_d   = cand_rot_q;
      mv_grav_d    = mv_grav_q;
      gcnt_d       = gcnt_q;
      score_d      = score_q;
      drw_clear_d  = drw_clear_q;
      chk_start_d  = 1'b0;
      drw_start_d  = 1'b0;
      lock_start_d = 1'b0;
      clr_start_d  = 1'b0;
      rdw_start_d  = 1'b0;
`ifdef TETRIS_SEQ_LEVEL_EN
      level_d  = level_q;
      rows_d   = rows_q;
      rows_sum = rows_q + 4'(rows_sat);
`endif
      unique case (state_q)
         StIdle: begin
            if (go_rise) state_d = StSpawn;
         end
         StSpawn: begin
            piece_d     = rng_q;
            cur_x_d     = XW'(SPAWN_X);
            cur_y_d     = '0;
            cur_rot_d   = 2'd0;
            cand_x_d    = XW'(SPAWN_X);
            cand_y_d    = '0;
            cand_rot_d  = 2'd0;
            mv_grav_d   = 1'b0;
            gcnt_d      = '0;
            chk_start_d = 1'b1;
            state_d     = StSchk;
         end
         StSchk: begin
            if (bus.chk_done) begin
               if (bus.chk_hit) begin
                  state_d = StOver;
               end else begin
                  drw_clear_d = 1'b0;
                  drw_start_d = 1'b1;
                  state_d     = StDraw;
               end
            end
         end
         StWaitIn: begin
            // A met gravity threshold clears the counter even when a player move wins.
            gcnt_d = grav_fire ? '0 : gcnt_q + CW'(1);
            if (rotate_rise) begin
               cand_x_d    = cur_x_q;
               cand_y_d    = cur_y_q;
               cand_rot_d  = cur_rot_q + 2'd1;
               mv_grav_d   = 1'b0;
               chk_start_d = 1'b1;
               state_d     = StMchk;
            end else if (left_rise) begin
               if (cur_x_q != '0) begin
                  cand_x_d    = cur_x_q - XW'(1);
                  cand_y_d    = cur_y_q;
                  cand_rot_d  = cur_rot_q;
                  mv_grav_d   = 1'b0;
                  chk_start_d = 1'b1;
                  state_d     = StMchk;
               end
            end else if (right_rise) begin
               if (cur_x_q != XW'(BOARD_W - 1)) begin
                  cand_x_d    = cur_x_q + XW'(1);
                  cand_y_d    = cur_y_q;
                  cand_rot_d  = cur_rot_q;
                  mv_grav_d   = 1'b0;
                  chk_start_d = 1'b1;
                  state_d     = StMchk;
               end
            end else if (grav_fire) begin
               cand_x_d    = cur_x_q;
               cand_y_d    = cur_y_q + YW'(1);
               cand_rot_d  = cur_rot_q;
               mv_grav_d   = 1'b1;
               chk_start_d = 1'b1;
               state_d     = StMchk;
            end
         end
         StMchk: begin
            if (bus.chk_done) begin
               if (!bus.chk_hit) begin
                  drw_clear_d = 1'b1;
                  drw_start_d = 1'b1;
                  state_d     = StErase;
               end else if (mv_grav_q) begin
                  lock_start_d = 1'b1;
                  state_d      = StLock;
               end else begin
                  state_d = StWaitIn;
               end
            end
         end
         StErase: begin
            if (bus.drw_done) begin
               cur_x_d     = cand_x_q;
               cur_y_d     = cand_y_q;
               cur_rot_d   = cand_rot_q;
               drw_clear_d = 1'b0;
               drw_start_d = 1'b1;
               state_d     = StDraw;
            end
         end
         StDraw: begin
            if (bus.drw_done) state_d = StWaitIn;
         end
         StLock: begin
            if (bus.lock_done) begin
               clr_start_d = 1'b1;
               state_d     = StClr;
            end
         end
         StClr: begin
            if (bus.clr_done) begin
               score_d = score_sat;
`ifdef TETRIS_SEQ_LEVEL_EN
               if (rows_sum >= 4'd10) begin
                  rows_d = rows_sum - 4'd10;
                  if (level_q != 4'd15) level_d = level_q + 4'd1;
               end else begin
                  rows_d = rows_sum;
               end
`endif
               if (rows_sat == 3'd0) begin
                  state_d = StSpawn;
               end else begin
                  rdw_start_d = 1'b1;
                  state_d     = StRedraw;
               end
            end
         end
         StRedraw: begin
            if (bus.rdw_done) state_d = StSpawn;
         end
         StOver: begin
            if (go_rise) begin
               score_d = '0;
`ifdef TETRIS_SEQ_LEVEL_EN
               level_d = 4'd0;
               rows_d  = 4'd0;
`endif
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         rng_q        <= 3'd0;
         piece_q      <= 3'd0;
         cur_x_q      <= XW'(SPAWN_X);
         cur_y_q      <= '0;
         cur_rot_q    <= 2'd0;
         cand_x_q     <= XW'(SPAWN_X);
         cand_y_q     <= '0;
         cand_rot_q   <= 2'd0;
         mv_grav_q    <= 1'b0;
         gcnt_q       <= '0;
         score_q      <= '0;
         chk_start_q  <= 1'b0;
         drw_start_q  <= 1'b0;
         drw_clear_q  <= 1'b0;
         lock_start_q <= 1'b0;
         clr_start_q  <= 1'b0;
         rdw_start_q  <= 1'b0;
         // Load the live levels so an input held through reset gives no edge.
         go_prev_q     <= go_i;
         left_prev_q   <= left_i;
         right_prev_q  <= right_i;
         rotate_prev_q <= rotate_i;
`ifdef TETRIS_SEQ_LEVEL_EN
         level_q <= 4'd0;
         rows_q  <= 4'd0;
`endif
      end else begin
         state_q      <= state_d;
         rng_q        <= rng_d;
         piece_q      <= piece_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         cur_rot_q    <= cur_rot_d;
         cand_x_q     <= cand_x_d;
         cand_y_q     <= cand_y_d;
         cand_rot_q   <= cand_rot_d;
         mv_grav_q    <= mv_grav_d;
         gcnt_q       <= gcnt_d;
         score_q      <= score_d;
         chk_start_q  <= chk_start_d;
         drw_start_q  <= drw_start_d;
         drw_clear_q  <= drw_clear_d;
         lock_start_q <= lock_start_d;
         clr_start_q  <= clr_start_d;
         rdw_start_q  <= rdw_start_d;
         go_prev_q     <= go_i;
         left_prev_q   <= left_i;
         right_prev_q  <= right_i;
         rotate_prev_q <= rotate_i;
`ifdef TETRIS_SEQ_LEVEL_EN
         level_q <= level_d;
         rows_q  <= rows_d;
`endif
      end
   end

   assign bus.chk_start  = chk_start_q;
   assign bus.chk_x      = cand_x_q;
   assign bus.chk_y      = cand_y_q;
   assign bus.chk_rot    = cand_rot_q;
   assign bus.drw_start  = drw_start_q;
   assign bus.drw_clear  = drw_clear_q;
   assign bus.drw_x      = cur_x_q;
   assign bus.drw_y      = cur_y_q;
   assign bus.drw_rot    = cur_rot_q;
   assign bus.lock_start = lock_start_q;
   assign bus.clr_start  = clr_start_q;
   assign bus.rdw_start  = rdw_start_q;

   assign piece_o     = piece_q;
   assign game_over_o = (state_q == StOver);
   assign score_o     = score_q;
   assign state_o     = state_q;
`ifdef TETRIS_SEQ_LEVEL_EN
   assign level_o     = level_q;
`endif

endmodule

// File: tb/tb_tetris_sequencer.sv
// Directed bench for tetris_sequencer: table-driven player moves and line clears, plus
// hand-written sequences for spawn, game over, soft drop and mid-handshake reset.
module tb_tetris_sequencer;
   localparam int unsigned BW = 10;
   localparam int unsigned BH = 24;
   localparam int unsigned GC = 20;
   localparam int unsigned SD = 8;
   localparam int unsigned XW = $clog2(BW);
   localparam int unsigned YW = $clog2(BH);

   localparam int S_IDLE = 0, S_SPAWN = 1, S_WAITIN = 3, S_MCHK = 4;
   localparam int S_LOCK = 7, S_REDRAW = 9, S_OVER = 10;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic go = 1'b0, left = 1'b0, right = 1'b0, rotate = 1'b0, drop = 1'b0;
   logic [2:0]  piece;
   logic        game_over;
   logic [15:0] score;
   logic [3:0]  state;
`ifdef TETRIS_SEQ_LEVEL_EN
   logic [3:0]  level;
`endif

   always #5 clk = ~clk;

   tetris_sequencer_if #(.XW(XW), .YW(YW)) bus ();

   tetris_sequencer #(
      .BOARD_W(BW), .BOARD_H(BH), .SPAWN_X(4), .GRAVITY_CYCLES(GC), .SOFT_DIV(SD), .SCORE_W(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .go_i(go), .left_i(left), .right_i(right), .rotate_i(rotate), .drop_i(drop),
      .piece_o(piece), .game_over_o(game_over), .score_o(score),
`ifdef TETRIS_SEQ_LEVEL_EN
      .level_o(level),
`endif
      .state_o(state)
   );

   int n_pass = 0;
   int n_chk = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic sig_of(input int ch);
      case (ch)
         0:       return bus.chk_start;
         1:       return bus.drw_start;
         2:       return bus.lock_start;
         3:       return bus.clr_start;
         default: return bus.rdw_start;
      endcase
   endfunction

   task automatic wait_start(input int ch, input string nm, input int budget);
      int t = 0;
      while (!sig_of(ch) && t < budget) begin
         step();
         t++;
      end
      if (!sig_of(ch)) check({nm, "_timeout"}, 0, 1);
   endtask

   // Replies with done three cycles after the start pulse seen at the current negedge.
   task automatic reply(input int ch, input logic hit, input logic [2:0] rows);
      step();
      step();
      case (ch)
         0: begin bus.chk_done = 1'b1; bus.chk_hit = hit; end
         1: bus.drw_done = 1'b1;
         2: bus.lock_done = 1'b1;
         3: begin bus.clr_done = 1'b1; bus.clr_rows = rows; end
         default: bus.rdw_done = 1'b1;
      endcase
      step();
      bus.chk_done = 1'b0; bus.chk_hit = 1'b0; bus.drw_done = 1'b0; bus.lock_done = 1'b0;
      bus.clr_done = 1'b0; bus.clr_rows = 3'd0; bus.rdw_done = 1'b0;
   endtask

   task automatic expect_chk(input string nm, input int x, input int y, input int r,
                             input logic hit);
      wait_start(0, nm, 40);
      check({nm, "_x"}, bus.chk_x, x);
      check({nm, "_y"}, bus.chk_y, y);
      check({nm, "_rot"}, bus.chk_rot, r);
      reply(0, hit, 3'd0);
   endtask

   task automatic expect_drw(input string nm, input logic clr, input int x, input int y,
                             input int r);
      wait_start(1, nm, 10);
      check({nm, "_clear"}, bus.drw_clear, clr);
      check({nm, "_x"}, bus.drw_x, x);
      check({nm, "_y"}, bus.drw_y, y);
      check({nm, "_rot"}, bus.drw_rot, r);
      reply(1, 1'b0, 3'd0);
   endtask

   task automatic wait_state(input int st, input int budget);
      int t = 0;
      while (int'(state) != st && t < budget) begin
         step();
         t++;
      end
      check("wait_state", state, st);
   endtask

   typedef struct {
      logic rot, l, r;
      logic hit;
      logic exp_chk;
      int   ex, ey, er;
   } mv_t;

   typedef struct {
      logic [2:0] rows;
      int         score;
      logic       redraw;
      int         per;
      int         lvl;
   } clr_t;

   mv_t  mv_tab[12];
   clr_t clr_tab[4];

   initial begin
      int ax, ay, ar, c0;
      bus.chk_done = 1'b0; bus.chk_hit = 1'b0; bus.drw_done = 1'b0; bus.lock_done = 1'b0;
      bus.clr_done = 1'b0; bus.clr_rows = 3'd0; bus.rdw_done = 1'b0;

      // Moves from anchor (4,1,0); rotation stays 0 so the wall combo checks rot 1.
      mv_tab[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1, 0};
      mv_tab[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4, 1, 0};
      mv_tab[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1, 1};
      mv_tab[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1, 1};
      mv_tab[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1, 0};
      mv_tab[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4, 1, 0};
      mv_tab[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1, 0};
      mv_tab[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 0};
      mv_tab[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 0};
      mv_tab[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0};
      mv_tab[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 1};
      mv_tab[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 0};

      // Score starts at 8 (4 rows) before this table.
      clr_tab[0] = '{3'd0, 8, 1'b0, 20, 0};
      clr_tab[1] = '{3'd7, 16, 1'b1, 20, 0};
      clr_tab[2] = '{3'd2, 19, 1'b1, 20, 1};
`ifdef TETRIS_SEQ_LEVEL_EN
      clr_tab[3] = '{3'd1, 20, 1'b1, 10, 1};
`else
      clr_tab[3] = '{3'd1, 20, 1'b1, 20, 0};
`endif

      // Reset values
      repeat (3) step();
      check("rst_state", state, S_IDLE);
      check("rst_chk_start", bus.chk_start, 0);
      check("rst_drw_start", bus.drw_start, 0);
      check("rst_drw_clear", bus.drw_clear, 0);
      check("rst_lock_start", bus.lock_start, 0);
      check("rst_game_over", game_over, 0);
      check("rst_score", score, 0);
      check("rst_piece", piece, 0);
      check("rst_anchor_x", bus.drw_x, 4);
      check("rst_anchor_y", bus.drw_y, 0);
      reset_n = 1'b1;
      step();
      check("idle_hold", state, S_IDLE);

      // Start and first descent
      go = 1'b1;
      step();
      check("go_spawn", state, S_SPAWN);
      go = 1'b0;
      expect_chk("spawn_chk", 4, 0, 0, 1'b0);
      check("piece_range", piece <= 3'd6, 1);
      expect_drw("spawn_drw", 1'b0, 4, 0, 0);
      wait_state(S_WAITIN, 5);
      c0 = cyc;
      wait_start(0, "grav0", 40);
      check("grav0_period", cyc - c0, GC);
      expect_chk("grav0", 4, 1, 0, 1'b0);
      expect_drw("grav0_erase", 1'b1, 4, 0, 0);
      expect_drw("grav0_draw", 1'b0, 4, 1, 0);
      ax = 4; ay = 1; ar = 0;

      // Player moves and the left-wall pre-filter
      for (int i = 0; i < 12; i++) begin
         wait_state(S_WAITIN, 20);
         rotate = mv_tab[i].rot; left = mv_tab[i].l; right = mv_tab[i].r;
         step();
         rotate = 1'b0; left = 1'b0; right = 1'b0;
         if (mv_tab[i].exp_chk) begin
            expect_chk($sformatf("mv%0d", i), mv_tab[i].ex, mv_tab[i].ey, mv_tab[i].er,
                       mv_tab[i].hit);
            if (!mv_tab[i].hit) begin
               expect_drw($sformatf("mv%0d_erase", i), 1'b1, ax, ay, ar);
               expect_drw($sformatf("mv%0d_draw", i), 1'b0, mv_tab[i].ex, mv_tab[i].ey,
                          mv_tab[i].er);
               ax = mv_tab[i].ex; ay = mv_tab[i].ey; ar = mv_tab[i].er;
            end
         end else begin
            logic seen = 1'b0;
            for (int k = 0; k < 4; k++) begin
               if (bus.chk_start || int'(state) != S_WAITIN) seen = 1'b1;
               step();
            end
            check($sformatf("mv%0d_no_chk", i), seen, 0);
         end
      end

      // Gravity hit locks the piece; four rows cleared
      expect_chk("lock_grav", 1, 2, 0, 1'b1);
      wait_start(2, "lock", 10);
      check("lock_state", state, S_LOCK);
      reply(2, 1'b0, 3'd0);
      wait_start(3, "clr", 10);
      reply(3, 1'b0, 3'd4);
      check("clr4_score", score, 8);
      check("clr4_redraw", bus.rdw_start, 1);
      check("clr4_state", state, S_REDRAW);
      reply(4, 1'b0, 3'd0);
      check("respawn", state, S_SPAWN);
`ifdef TETRIS_SEQ_LEVEL_EN
      check("level_after4", level, 0);
`endif

      // Line-clear table: scoring, saturation of clr_rows, redraw skip, level period
      for (int i = 0; i < 4; i++) begin
         expect_chk($sformatf("c%0d_spawn", i), 4, 0, 0, 1'b0);
         expect_drw($sformatf("c%0d_draw", i), 1'b0, 4, 0, 0);
         c0 = cyc;
         wait_start(0, $sformatf("c%0d_grav", i), 40);
         check($sformatf("c%0d_period", i), cyc - c0, clr_tab[i].per);
         expect_chk($sformatf("c%0d_grav", i), 4, 1, 0, 1'b1);
         wait_start(2, $sformatf("c%0d_lock", i), 10);
         reply(2, 1'b0, 3'd0);
         wait_start(3, $sformatf("c%0d_clr", i), 10);
         reply(3, 1'b0, clr_tab[i].rows);
         check($sformatf("c%0d_score", i), score, clr_tab[i].score);
         check($sformatf("c%0d_redraw", i), bus.rdw_start, clr_tab[i].redraw);
`ifdef TETRIS_SEQ_LEVEL_EN
         check($sformatf("c%0d_level", i), level, clr_tab[i].lvl);
`endif
         if (clr_tab[i].redraw) reply(4, 1'b0, 3'd0);
         check($sformatf("c%0d_spawn_state", i), state, S_SPAWN);
      end

      // Game over and restart
      expect_chk("over_chk", 4, 0, 0, 1'b1);
      check("over_state", state, S_OVER);
      check("over_flag", game_over, 1);
      check("over_score", score, 20);
      go = 1'b1;
      step();
      check("over_exit_idle", state, S_IDLE);
      check("over_exit_score", score, 0);
      check("over_exit_flag", game_over, 0);
      go = 1'b0;
      step();
      step();
      check("idle_stay", state, S_IDLE);
      go = 1'b1;
      step();
      check("restart_spawn", state, S_SPAWN);
      go = 1'b0;

      // Soft drop: 20/8 -> gravity every 2 cycles
      expect_chk("sd_spawn", 4, 0, 0, 1'b0);
      expect_drw("sd_draw", 1'b0, 4, 0, 0);
      wait_state(S_WAITIN, 5);
      drop = 1'b1;
      c0 = cyc;
      wait_start(0, "sd0", 10);
      check("sd0_period", cyc - c0, 2);
      expect_chk("sd0", 4, 1, 0, 1'b0);
      expect_drw("sd0_erase", 1'b1, 4, 0, 0);
      expect_drw("sd0_draw", 1'b0, 4, 1, 0);
      c0 = cyc;
      wait_start(0, "sd1", 10);
      check("sd1_period", cyc - c0, 2);
      check("sd1_y", bus.chk_y, 2);

      // Reset while waiting in MCHK, then a late chk_done
      step();
      check("mchk_wait", state, S_MCHK);
      reset_n = 1'b0;
      step();
      check("mrst_state", state, S_IDLE);
      check("mrst_chk_start", bus.chk_start, 0);
      check("mrst_drw_start", bus.drw_start, 0);
      check("mrst_drw_clear", bus.drw_clear, 0);
      check("mrst_chk_x", bus.chk_x, 4);
      check("mrst_chk_y", bus.chk_y, 0);
      check("mrst_anchor_y", bus.drw_y, 0);
      check("mrst_piece", piece, 0);
      check("mrst_game_over", game_over, 0);
      reset_n = 1'b1;
      drop = 1'b0;
      bus.chk_done = 1'b1;
      step();
      bus.chk_done = 1'b0;
      step();
      step();
      check("late_done_state", state, S_IDLE);
      check("late_done_lock", bus.lock_start, 0);
      check("late_done_drw", bus.drw_start, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end
endmodule
